// File: rtl/negate_arbiter.sv
// negate_arbiter
// Round-robin scheduler that shares one combinational two's-complement
// negation unit (twosComp) among NREQ requesters. One operand is accepted per
// transaction and presented to the shared unit for one cycle. The unit's result
// is captured and returned with the requester ID on a valid/ready channel.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [NREQ]        requester i has an operand pending
//   req_operand  [NREQ*WIDTH]  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    [NREQ]        one-hot accept, only ever set while idle
//   tc_operand   [WIDTH]       registered operand to the shared twosComp unit
//   tc_result    [WIDTH]       combinational negation returned by the unit
//   rsp_valid                  response available
//   rsp_ready                  consumer accepts the response
//   rsp_id       [IDW]         requester that owns the response
//   rsp_data     [WIDTH]       captured tc_result
//   rsp_ovf                    operand was the most-negative value
//   busy                       transaction in flight (not idle)
module negate_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_operand,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        tc_operand,
    input  logic [WIDTH-1:0]        tc_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_ovf,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_RESP  = 2'b10;

    // The only operand whose negation does not fit: MSB set, all others clear.
    function automatic logic is_min_neg(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] pattern;
        pattern = {1'b1, {(WIDTH-1){1'b0}}};
        return (value == pattern);
    endfunction

    logic [1:0]       state_r;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   id_r;
    logic [WIDTH-1:0] tc_operand_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_ovf_r;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;
    int               cand_s;
    logic [WIDTH-1:0] sel_operand_s;
    logic [NREQ-1:0]  req_ready_s;

    // Round-robin search: first pending requester strictly after ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = int'(ptr_r) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDW-1:0];
            end else begin
                // an earlier winner in the search order is kept
            end
        end
    end

    // Operand of the current winner.
    always_comb begin
        sel_operand_s = req_operand[int'(grant_idx_s)*WIDTH +: WIDTH];
    end

    // Accept strobe: only while idle, and forced low while reset is asserted
    // so that every output reads zero immediately on reset.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ST_IDLE) && rst_n && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Transaction FSM with operand, ID and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= IDW'(NREQ - 1);
            id_r         <= '0;
            tc_operand_r <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_data_r   <= '0;
            rsp_ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        tc_operand_r <= sel_operand_s;
                        id_r         <= grant_idx_s;
                        ptr_r        <= grant_idx_s;
                        state_r      <= ST_ISSUE;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // tc_operand has been stable for the whole cycle, so the
                    // unit's combinational result is settled at this edge.
                    rsp_data_r  <= tc_result;
                    rsp_id_r    <= id_r;
                    rsp_ovf_r   <= is_min_neg(tc_operand_r);
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign tc_operand = tc_operand_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_ovf    = rsp_ovf_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: doc/negate_arbiter.md
Name: negate_arbiter

Overview:
Round-robin scheduler that shares one combinational two's-complement negation unit among NREQ requesters. It accepts an operand from one requester per transaction and drives it to the shared unit. It registers the unit's result and returns it with the requester ID over a valid/ready response channel. It sits between the operand sources and the single twosComp instance in the PCFG datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand/result width in bits
IDW, 2, requester ID width; must equal ceil(log2(NREQ))

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  bit i high: requester i has an operand pending
req_operand  input  NREQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot accept; handshake on requester i completes at the edge where req_valid[i] and req_ready[i] are both high
tc_operand  output  WIDTH  operand driven to the shared twosComp unit (registered)
tc_result  input  WIDTH  negated result returned combinationally by the twosComp unit
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts the response
rsp_id  output  IDW  index of the requester that owns the response
rsp_data  output  WIDTH  captured tc_result
rsp_ovf  output  1  operand was the most-negative value (MSB=1, others 0); negation overflowed
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-safe deassert assumed upstream): state=IDLE. req_ready, tc_operand, rsp_valid, rsp_id, rsp_data, rsp_ovf and busy all 0. Priority pointer ptr=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req_valid, select g = first set bit searching from ptr+1 upward, modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle. At most one bit is set; req_ready is 0 in all other states.
  - At the edge: op_reg<=operand[g]; id_reg<=g; ptr<=g; state<=ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE: tc_operand=op_reg for the whole cycle.
  - At the edge: rsp_data<=tc_result; rsp_id<=id_reg; rsp_ovf<=(op_reg==MSB-only pattern); rsp_valid<=1; state<=RESP.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_ovf are held stable until rsp_valid&&rsp_ready.
  - On the handshake edge: rsp_valid<=0; state<=IDLE.
  - No new grant in the handshake cycle.
- Latency: acceptance edge N -> rsp_valid high in cycle N+2. Minimum period is 3 cycles per transaction with rsp_ready held high.
- tc_operand holds the last issued value outside ISSUE. Width is strictly WIDTH; no extension.
- Arithmetic is done only by the external unit. rsp_ovf is the only locally computed flag. 0 -> 0 with rsp_ovf=0. MSB-only -> itself with rsp_ovf=1.
- A requester may drop req_valid before it is granted (withdrawal is legal). After raising req_valid, it must hold req_operand stable until its handshake.
- req_valid changes in ISSUE or RESP have no effect until the next IDLE cycle.
- rsp_ready high while rsp_valid is 0 is ignored.
- Reset asserted mid-transaction (ISSUE or RESP): the transaction is dropped, all outputs clear immediately, and ptr returns to NREQ-1.

Test Plan:
- Reset release, req_valid=0001, operand0=0011 -> req_ready=0001 in acceptance cycle N. tc_operand=0011 in N+1. rsp_valid=1, rsp_data=1101, rsp_id=0, rsp_ovf=0 in N+2.
- req_valid=1111 held, operands 1,2,3,4, rsp_ready=1 -> grants in order 0,1,2,3, one every 3 cycles. rsp_data = 1111, 1110, 1101, 1100.
- Operand 1000 -> rsp_data=1000, rsp_ovf=1. Operand 0000 -> rsp_data=0000, rsp_ovf=0.
- rsp_ready low for 5 cycles during RESP with req_valid=1111 -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0000; IDLE is re-entered the cycle after rsp_ready rises.
- rst_n pulsed low during ISSUE -> all outputs 0 without waiting for a clock edge. After release with req_valid=1010, requester 1 is granted first.
- req_valid[1] and req_valid[3] held continuously -> grant sequence 1,3,1,3; neither requester is starved.
